// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller.
// Converts an unsigned binary value to BCD with a sequential double-dabble
// converter, then time-multiplexes NUM_DIGITS digits onto shared cathodes.
// Supports leading-zero blanking, a decimal point per digit and overflow dashes.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   value    unsigned binary value to display
//   dp_mask  1 lights the decimal point of that digit (bit 0 = rightmost)
//   anode    active-low one-hot digit enable
//   ssd_out  active-low segments {a,b,c,d,e,f,g}
//   dp       active-low decimal point
//   busy     high while a BCD conversion is in progress
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            ssd_out,
  output logic                  dp,
  output logic                  busy
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] last_val;
  logic [DATA_W-1:0] shift_reg;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  disp_bcd;
  logic              ovf;
  logic              disp_ovf;
  logic [CNT_W-1:0]  bit_cnt;
  logic              load;
  logic              step;
  logic              commit;

  logic [PS_W-1:0]       prescaler;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [3:0]            nib;
  logic                  upper_zero;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  assign bcd_adj = add3_all(bcd);
  assign busy    = (state == CONV);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (value != last_val) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (bit_cnt == '0) state_next = DONE;
      end
      DONE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and displayed result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_val <= '0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        last_val <= value;
        bit_cnt  <= CNT_W'(DATA_W - 1);
      end else if (step) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
      // Digits and overflow flag change together so no torn frame is shown.
      if (commit) begin
        disp_bcd <= bcd;
        disp_ovf <= ovf;
      end
    end
  end

  // Conversion working registers; always reinitialised by load
  always_ff @(posedge clk) begin
    if (load) begin
      shift_reg <= value;
      bcd       <= '0;
      ovf       <= 1'b0;
    end else if (step) begin
      {bcd, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
      // A one leaving the top nibble means the value needs more digits.
      ovf <= ovf | bcd_adj[BCD_W-1];
    end
  end

  always_comb begin
    anode_next = '1;
    nib        = 4'd0;
    dp_next    = 1'b1;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        anode_next[i] = 1'b0;
        nib           = disp_bcd[4*i +: 4];
        dp_next       = ~dp_mask[i];
      end
      if (IDX_W'(i) >= digit_idx && disp_bcd[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (disp_ovf)
      seg_next = SEG_DASH;
    else if (BLANK_LZ != 0 && digit_idx != '0 && upper_zero)
      seg_next = SEG_BLANK;
    else
      seg_next = seg_decode(nib);
  end

  // Scan counters and registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      digit_idx <= '0;
      anode     <= '1;
      ssd_out   <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      if (prescaler == PS_W'(SCAN_DIV - 1)) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      anode   <= anode_next;
      ssd_out <= seg_next;
      dp      <= dp_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl: three instances with different digit count,
// scan divider and blanking mode, checked every cycle against a value-level
// model, plus literal segment checks on selected digits.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic [7:0]  dp_mask = 8'h00;

  logic [7:0] an0, an2;
  logic [3:0] an1;
  logic [6:0] sg0, sg1, sg2;
  logic       dp0, dp1, dp2, bz0, bz1, bz2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.NUM_DIGITS(8), .DATA_W(16), .SCAN_DIV(4), .BLANK_LZ(1)) u0 (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
    .anode(an0), .ssd_out(sg0), .dp(dp0), .busy(bz0));
  ssd_scan_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .SCAN_DIV(3), .BLANK_LZ(1)) u1 (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask[3:0]),
    .anode(an1), .ssd_out(sg1), .dp(dp1), .busy(bz1));
  ssd_scan_ctrl #(.NUM_DIGITS(8), .DATA_W(16), .SCAN_DIV(2), .BLANK_LZ(0)) u2 (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
    .anode(an2), .ssd_out(sg2), .dp(dp2), .busy(bz2));

  function automatic int nd_of(int k);
    return (k == 1) ? 4 : 8;
  endfunction
  function automatic int sd_of(int k);
    return (k == 0) ? 4 : ((k == 1) ? 3 : 2);
  endfunction
  function automatic bit bl_of(int k);
    return k != 2;
  endfunction
  function automatic longint p10(int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  function automatic logic [7:0] ones(int k);
    return (nd_of(k) == 8) ? 8'hFF : 8'h0F;
  endfunction
  function automatic logic [6:0] seg7(longint n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction
  function automatic logic [6:0] exp_seg(int k, longint disp, bit ovf, int idx);
    if (ovf) return 7'b1111110;
    if (bl_of(k) && idx > 0 && disp < p10(idx)) return 7'h7F;
    return seg7((disp / p10(idx)) % 10);
  endfunction

  // Model: displayed number as an integer, conversion as a latency timer.
  longint     m_last[3], m_cap[3], m_disp[3];
  int         m_rem[3], m_pres[3], m_idx[3];
  bit         m_dovf[3];
  logic [7:0] e_an[3];
  logic [6:0] e_sg[3];
  logic       e_dp[3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_last[k] <= 0; m_cap[k] <= 0; m_disp[k] <= 0; m_dovf[k] <= 1'b0;
        m_rem[k] <= 0; m_pres[k] <= 0; m_idx[k] <= 0;
        e_an[k] <= ones(k); e_sg[k] <= 7'h7F; e_dp[k] <= 1'b1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        e_an[k] <= ones(k) & ~(8'h01 << m_idx[k]);
        e_sg[k] <= exp_seg(k, m_disp[k], m_dovf[k], m_idx[k]);
        e_dp[k] <= ~dp_mask[m_idx[k]];
        if (m_pres[k] == sd_of(k) - 1) begin
          m_pres[k] <= 0;
          m_idx[k]  <= (m_idx[k] + 1) % nd_of(k);
        end else begin
          m_pres[k] <= m_pres[k] + 1;
        end
        if (m_rem[k] == 0) begin
          if (longint'(value) != m_last[k]) begin
            m_last[k] <= longint'(value);
            m_cap[k]  <= longint'(value);
            m_rem[k]  <= 17;
          end
        end else begin
          m_rem[k] <= m_rem[k] - 1;
          if (m_rem[k] == 1) begin
            m_disp[k] <= m_cap[k] % p10(nd_of(k));
            m_dovf[k] <= m_cap[k] >= p10(nd_of(k));
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: digit never selected within 64 cycles", nm);
  endtask

  always @(negedge clk) begin
    chk("an0", {24'd0, an0}, {24'd0, e_an[0]});
    chk("sg0", {25'd0, sg0}, {25'd0, e_sg[0]});
    chk("dp0", {31'd0, dp0}, {31'd0, e_dp[0]});
    chk("bz0", {31'd0, bz0}, {31'd0, m_rem[0] >= 2});
    chk("an1", {28'd0, an1}, {24'd0, e_an[1]});
    chk("sg1", {25'd0, sg1}, {25'd0, e_sg[1]});
    chk("dp1", {31'd0, dp1}, {31'd0, e_dp[1]});
    chk("bz1", {31'd0, bz1}, {31'd0, m_rem[1] >= 2});
    chk("an2", {24'd0, an2}, {24'd0, e_an[2]});
    chk("sg2", {25'd0, sg2}, {25'd0, e_sg[2]});
    chk("dp2", {31'd0, dp2}, {31'd0, e_dp[2]});
    chk("bz2", {31'd0, bz2}, {31'd0, m_rem[2] >= 2});
  end

  task automatic lit0(int d, logic [6:0] seg, string nm);
    logic [7:0] tgt;
    int n = 0;
    tgt = ~(8'h01 << d);
    while (an0 !== tgt && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) timeout(nm);
    else chk(nm, {25'd0, sg0}, {25'd0, seg});
  endtask

  task automatic lit1(int d, logic [6:0] seg, string nm);
    logic [3:0] tgt;
    int n = 0;
    tgt = ~(4'h1 << d);
    while (an1 !== tgt && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) timeout(nm);
    else chk(nm, {25'd0, sg1}, {25'd0, seg});
  endtask

  task automatic lit2(int d, logic [6:0] seg, logic dpx, string nm);
    logic [7:0] tgt;
    int n = 0;
    tgt = ~(8'h01 << d);
    while (an2 !== tgt && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) timeout(nm);
    else begin
      chk(nm, {25'd0, sg2}, {25'd0, seg});
      chk({nm, "_dp"}, {31'd0, dp2}, {31'd0, dpx});
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Reset state and asynchronous reset in the middle of a scan
    lit0(0, 7'b0000001, "rst_d0");
    lit0(1, 7'h7F, "rst_d1");
    repeat (5) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_an0", {24'd0, an0}, 32'hFF);
    chk("async_sg0", {25'd0, sg0}, 32'h7F);
    chk("async_dp0", {31'd0, dp0}, 32'd1);
    chk("async_an1", {28'd0, an1}, 32'hF);
    @(negedge clk); #2 reset = 1'b0;
    lit0(0, 7'b0000001, "post_rst_d0");
    lit0(7, 7'h7F, "post_rst_d7");

    // 1234 on eight digits
    @(negedge clk); value = 16'd1234;
    bc = 0;
    repeat (24) begin @(negedge clk); if (bz0) bc++; end
    chk("busy_len", bc, 16);
    lit0(0, 7'b1001100, "v1234_d0");
    lit0(1, 7'b0000110, "v1234_d1");
    lit0(2, 7'b0010010, "v1234_d2");
    lit0(3, 7'b1001111, "v1234_d3");
    lit0(4, 7'h7F, "v1234_d4");
    lit2(4, 7'b0000001, 1'b1, "v1234_nolz_d4");

    // Overflow on four digits, then the largest value that fits
    @(negedge clk); value = 16'd12345;
    repeat (22) @(negedge clk);
    lit1(0, 7'b1111110, "ovf_d0");
    lit1(3, 7'b1111110, "ovf_d3");
    lit0(4, 7'b1001111, "v12345_d4");
    @(negedge clk); value = 16'd9999;
    repeat (22) @(negedge clk);
    lit1(0, 7'b0000100, "v9999_d0");
    lit1(3, 7'b0000100, "v9999_d3");

    // No blanking, decimal point on digit 2
    @(negedge clk); value = 16'd7; dp_mask = 8'h04;
    repeat (22) @(negedge clk);
    lit2(0, 7'b0001111, 1'b1, "v7_d0");
    lit2(1, 7'b0000001, 1'b1, "v7_d1");
    lit2(2, 7'b0000001, 1'b0, "v7_d2");
    lit2(7, 7'b0000001, 1'b1, "v7_d7");
    lit0(2, 7'h7F, "v7_blank_d2");
    chk("v7_blank_dp2", {31'd0, dp0}, 32'd0);

    // Value change during conversion is picked up by a second pass
    @(negedge clk); value = 16'd100; dp_mask = 8'h00;
    repeat (5) @(negedge clk);
    value = 16'd200;
    repeat (5) @(negedge clk);
    chk("busy_mid", {31'd0, bz0}, 32'd1);
    repeat (40) @(negedge clk);
    lit0(2, 7'b0010010, "v200_d2");

    // Reset in the middle of a conversion of 65535
    @(negedge clk); value = 16'd65535;
    repeat (8) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1 chk("rst_conv_busy", {31'd0, bz0}, 32'd0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_conv_d0", {25'd0, sg0}, 32'b0000001);
    repeat (24) @(negedge clk);
    lit0(0, 7'b0100100, "v65535_d0");
    lit0(4, 7'b0100000, "v65535_d4");
    lit0(5, 7'h7F, "v65535_d5");

    // Random values, masks, hold times and occasional resets
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      value = ($urandom % 3 == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom_range(0, 65535));
      dp_mask = 8'($urandom);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      if ($urandom % 8 == 0) pulse_reset();
    end
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
